// File: rtl/mcl_mem_responder.sv
// mcl_mem_responder
//   Manycore-link memory endpoint. Takes one 128-bit MCL request, decodes it,
//   does a load / store / byte-masked store on a local 32-bit word memory and
//   returns one 128-bit MCL response to the request's source coordinates.
//   Two-state FSM: IDLE accepts a request, RESP holds the response until
//   it is taken.
//
// Ports
//   clk_i, reset_i          clock, async active-high reset
//   my_x_i, my_y_i          this endpoint's coordinates (quasi-static)
//   req_v_i/req_i/req_ready_o   request channel (valid/ready)
//   rsp_v_o/rsp_o/rsp_ready_i   response channel (valid/ready)
//   load_cnt_o, store_cnt_o, err_cnt_o   saturating response counters
module mcl_mem_responder #(
  parameter int mem_els_p   = 1024,
  parameter int cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [7:0]             my_x_i,
  input  logic [7:0]             my_y_i,
  input  logic                   req_v_i,
  input  logic [127:0]           req_i,
  output logic                   req_ready_o,
  output logic                   rsp_v_o,
  output logic [127:0]           rsp_o,
  input  logic                   rsp_ready_i,
  output logic [cnt_width_p-1:0] load_cnt_o,
  output logic [cnt_width_p-1:0] store_cnt_o,
  output logic [cnt_width_p-1:0] err_cnt_o
);
  localparam int lg_els_lp = $clog2(mem_els_p);

  typedef struct packed {
    logic [15:0] padding;
    logic [31:0] addr;
    logic [7:0]  op;
    logic [7:0]  op_ex;
    logic [31:0] payload;
    logic [7:0]  src_y_cord;
    logic [7:0]  src_x_cord;
    logic [7:0]  y_cord;
    logic [7:0]  x_cord;
  } req_pkt_s;

  typedef struct packed {
    logic [39:0] padding;
    logic [7:0]  pkt_type;
    logic [31:0] data;
    logic [31:0] load_id;
    logic [7:0]  y_cord;
    logic [7:0]  x_cord;
  } rsp_pkt_s;

  localparam logic [7:0] pkt_ack_lp  = 8'h00;
  localparam logic [7:0] pkt_load_lp = 8'h01;
  localparam logic [7:0] pkt_err_lp  = 8'h02;

  typedef enum logic {IDLE, RESP} state_e;

  state_e         state_r;
  rsp_pkt_s       rsp_r;       // data field unused; load data comes from rd_data_r
  logic [31:0]    rd_data_r;
  logic [31:0]    mem [mem_els_p];

  req_pkt_s              req;
  logic [lg_els_lp-1:0]  idx;
  logic                  in_range, is_local, is_err, is_load, is_wr, req_hs;
  logic [3:0]            byte_en;
  rsp_pkt_s              rsp_n;

  assign req      = req_i;
  assign idx      = req.addr[lg_els_lp-1:0];
  assign in_range = (req.addr >> lg_els_lp) == 32'd0;
  assign is_local = (req.x_cord == my_x_i) && (req.y_cord == my_y_i);
  assign is_err   = !is_local || !in_range || (req.op > 8'd2);
  assign is_load  = !is_err && (req.op == 8'd0);
  assign is_wr    = !is_err && (req.op != 8'd0);
  // op=1 writes the whole word; op=2 uses the low nibble of op_ex as byte mask
  assign byte_en  = (req.op == 8'd1) ? 4'hF : req.op_ex[3:0];

  assign req_ready_o = (state_r == IDLE);
  assign rsp_v_o     = (state_r == RESP);
  assign req_hs      = req_v_i && req_ready_o && !reset_i;

  always_comb begin
    rsp_n          = '0;
    rsp_n.y_cord   = req.src_y_cord;
    rsp_n.x_cord   = req.src_x_cord;
    rsp_n.pkt_type = is_err ? pkt_err_lp : (is_load ? pkt_load_lp : pkt_ack_lp);
    rsp_n.load_id  = is_wr ? 32'd0 : req.payload;
  end

  // Memory has no reset; contents survive reset_i. The read is registered at
  // the accept edge and held, so backpressure never triggers a re-read.
  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      rd_data_r <= mem[idx];
      if (is_wr) begin
        for (int b = 0; b < 4; b++)
          if (byte_en[b]) mem[idx][8*b +: 8] <= req.payload[8*b +: 8];
      end
    end
  end

  // Reset clears pkt_type to ack, which forces the data field to zero.
  always_comb begin
    rsp_o = rsp_r;
    if (rsp_r.pkt_type == pkt_load_lp) rsp_o[79:48] = rd_data_r;
    else                               rsp_o[79:48] = '0;
  end

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      rsp_r       <= '0;
      load_cnt_o  <= '0;
      store_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      case (state_r)
        IDLE: if (req_v_i) begin
          rsp_r   <= rsp_n;
          state_r <= RESP;
        end
        RESP: if (rsp_ready_i) begin
          state_r <= IDLE;
          case (rsp_r.pkt_type)
            pkt_load_lp: load_cnt_o  <= sat_inc(load_cnt_o);
            pkt_ack_lp:  store_cnt_o <= sat_inc(store_cnt_o);
            default:     err_cnt_o   <= sat_inc(err_cnt_o);
          endcase
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcl_mem_responder.sv
module tb_mcl_mem_responder;
  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   my_x, my_y;
  logic         req_v, req_ready, rsp_v, rsp_ready;
  logic [127:0] req, rsp;
  logic [15:0]  load_cnt, store_cnt, err_cnt;
  // narrow-counter instance sharing all inputs, for saturation
  logic         req_ready_s, rsp_v_s;
  logic [127:0] rsp_s;
  logic [3:0]   lc_s, sc_s, ec_s;

  always #5 clk = ~clk;

  mcl_mem_responder #(.mem_els_p(1024), .cnt_width_p(16)) dut (
    .clk_i(clk), .reset_i(reset), .my_x_i(my_x), .my_y_i(my_y),
    .req_v_i(req_v), .req_i(req), .req_ready_o(req_ready),
    .rsp_v_o(rsp_v), .rsp_o(rsp), .rsp_ready_i(rsp_ready),
    .load_cnt_o(load_cnt), .store_cnt_o(store_cnt), .err_cnt_o(err_cnt));

  mcl_mem_responder #(.mem_els_p(1024), .cnt_width_p(4)) dut_s (
    .clk_i(clk), .reset_i(reset), .my_x_i(my_x), .my_y_i(my_y),
    .req_v_i(req_v), .req_i(req), .req_ready_o(req_ready_s),
    .rsp_v_o(rsp_v_s), .rsp_o(rsp_s), .rsp_ready_i(rsp_ready),
    .load_cnt_o(lc_s), .store_cnt_o(sc_s), .err_cnt_o(ec_s));

  int n_tests = 0, n_fail = 0;
  logic [127:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  op, op_ex;
    logic [31:0] pay;
    logic [7:0]  y, x;
    logic [7:0]  typ;
    logic [31:0] data, id;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t v(input logic [31:0] addr, input logic [7:0] op, op_ex,
                             input logic [31:0] pay, input logic [7:0] y, x, typ,
                             input logic [31:0] data, id);
    vec_t r;
    r.addr = addr; r.op = op; r.op_ex = op_ex; r.pay = pay; r.y = y; r.x = x;
    r.typ = typ; r.data = data; r.id = id;
    return r;
  endfunction

  function automatic logic [127:0] mk_req(input logic [31:0] addr, input logic [7:0] op, op_ex,
                                          input logic [31:0] pay, input logic [7:0] sy, sx, y, x);
    return {16'h0, addr, op, op_ex, pay, sy, sx, y, x};
  endfunction

  function automatic logic [127:0] mk_rsp(input logic [7:0] typ, input logic [31:0] data, id,
                                          input logic [7:0] y, x);
    return {40'h0, typ, data, id, y, x};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare at the negedge before the handshake edge.
  always @(negedge clk) begin
    if (!reset && rsp_v && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_unexpected: got %h expected none", rsp);
      end else begin
        chk("rsp", rsp, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [127:0] pkt, input logic [127:0] exp);
    int t = 0;
    while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got req_ready=0 expected 1");
    end else begin
      exp_q.push_back(exp);
      req_v = 1'b1; req = pkt;
      @(posedge clk); #1;
      req_v = 1'b0; req = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int nl, ns, ne;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl = 0, ns = 0, ne = 0;
    reset = 1'b1; req_v = 1'b0; req = '0; rsp_ready = 1'b1;
    my_x = 8'd2; my_y = 8'd1;
    #12;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_v", rsp_v, 0);
    chk("reset_rsp", rsp, 0);
    chk("reset_cnts", {load_cnt, store_cnt, err_cnt}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // addr, op, op_ex, payload, y, x, type, data, id
    vecs.push_back(v(0,    1, 0,     32'h0A0A0A0A, 1, 2, 0, 0, 0));
    vecs.push_back(v(5,    1, 0,     32'hCAFE0001, 1, 2, 0, 0, 0));
    vecs.push_back(v(5,    0, 0,     32'h77,       1, 2, 1, 32'hCAFE0001, 32'h77));
    vecs.push_back(v(9,    1, 8'hFF, 32'h11223344, 1, 2, 0, 0, 0));
    vecs.push_back(v(9,    2, 8'hF5, 32'hAABBCCDD, 1, 2, 0, 0, 0));
    vecs.push_back(v(9,    0, 0,     32'h1234,     1, 2, 1, 32'h11BB33DD, 32'h1234));
    vecs.push_back(v(9,    2, 8'h00, 32'hFFFFFFFF, 1, 2, 0, 0, 0));
    vecs.push_back(v(9,    0, 0,     32'h1,        1, 2, 1, 32'h11BB33DD, 32'h1));
    vecs.push_back(v(1023, 1, 0,     32'hDEADBEEF, 1, 2, 0, 0, 0));
    vecs.push_back(v(1023, 0, 0,     32'h2,        1, 2, 1, 32'hDEADBEEF, 32'h2));
    vecs.push_back(v(5,    1, 0,     32'h5555,     1, 7, 2, 0, 32'h5555));
    vecs.push_back(v(1024, 1, 0,     32'h6666,     1, 2, 2, 0, 32'h6666));
    vecs.push_back(v(5,    5, 0,     32'h7777,     1, 2, 2, 0, 32'h7777));
    vecs.push_back(v(5,    3, 0,     32'h8888,     1, 2, 2, 0, 32'h8888));
    vecs.push_back(v(5,    0, 0,     32'h9999,     9, 2, 2, 0, 32'h9999));
    vecs.push_back(v(5,    0, 0,     32'h3,        1, 2, 1, 32'hCAFE0001, 32'h3));
    vecs.push_back(v(0,    0, 0,     32'h4,        1, 2, 1, 32'h0A0A0A0A, 32'h4));

    for (int i = 0; i < vecs.size(); i++) begin
      logic [7:0] sy, sx;
      sy = 8'(3 + i); sx = 8'(4 + 2 * i);
      send(mk_req(vecs[i].addr, vecs[i].op, vecs[i].op_ex, vecs[i].pay, sy, sx, vecs[i].y, vecs[i].x),
           mk_rsp(vecs[i].typ, vecs[i].data, vecs[i].id, sy, sx));
      if (vecs[i].typ == 8'h01) nl++;
      else if (vecs[i].typ == 8'h00) ns++;
      else ne++;
    end
    drain();
    chk("load_cnt", load_cnt, nl);
    chk("store_cnt", store_cnt, ns);
    chk("err_cnt", err_cnt, ne);

    // Backpressure: response held, competing store refused.
    rsp_ready = 1'b0;
    send(mk_req(5, 0, 0, 32'hAB, 3, 4, 1, 2), mk_rsp(1, 32'hCAFE0001, 32'hAB, 3, 4));
    req_v = 1'b1; req = mk_req(5, 1, 0, 32'h00000BAD, 3, 4, 1, 2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_rsp_v", rsp_v, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_stable", rsp, mk_rsp(1, 32'hCAFE0001, 32'hAB, 3, 4));
    end
    @(posedge clk); #1;
    req_v = 1'b0; rsp_ready = 1'b1;
    drain();
    send(mk_req(5, 0, 0, 32'hAC, 3, 4, 1, 2), mk_rsp(1, 32'hCAFE0001, 32'hAC, 3, 4));
    drain();
    chk("bp_load_cnt", load_cnt, nl + 2);

    // Reset while a response is pending.
    rsp_ready = 1'b0;
    send(mk_req(9, 0, 0, 32'h55, 3, 4, 1, 2), mk_rsp(1, 32'h11BB33DD, 32'h55, 3, 4));
    @(negedge clk);
    chk("pre_reset_rsp_v", rsp_v, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_rsp_v", rsp_v, 0);
    chk("rst_rsp", rsp, 0);
    chk("rst_cnts", {load_cnt, store_cnt, err_cnt}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0; rsp_ready = 1'b1;
    chk("post_rst_req_ready", req_ready, 1);
    send(mk_req(9, 0, 0, 32'h56, 3, 4, 1, 2), mk_rsp(1, 32'h11BB33DD, 32'h56, 3, 4));
    drain();
    chk("post_rst_load_cnt", load_cnt, 1);

    // Saturation on the 4-bit instance: 19 stores.
    for (int i = 0; i < 19; i++)
      send(mk_req(100 + i, 1, 0, i, 3, 4, 1, 2), mk_rsp(0, 0, 0, 3, 4));
    drain();
    chk("sat_store_cnt16", store_cnt, 19);
    chk("sat_store_cnt4", sc_s, 4'hF);
    chk("sat_load_cnt4", lc_s, 1);
    send(mk_req(118, 0, 0, 32'h9, 3, 4, 1, 2), mk_rsp(1, 18, 32'h9, 3, 4));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mcl_mem_responder.md
Name: mcl_mem_responder

Overview:
- Manycore-link (MCL) endpoint that sits at the far end of the host request path.
- Accepts 128-bit MCL request packets, decodes them and performs loads or stores on a local 32-bit word memory.
- Returns one 128-bit MCL response packet per request, addressed back to the request's source coordinates.
- Serves as the responder counterpart to the host-side request packer, and as a memory endpoint in cosim and FPGA loopback builds.

Parameters:
- mem_els_p, 1024: number of 32-bit words in local memory; power of 2, at least 2.
- cnt_width_p, 16: width of the statistics counters.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- my_x_i  in  8  this endpoint's x coordinate; quasi-static
- my_y_i  in  8  this endpoint's y coordinate; quasi-static
- req_v_i  in  1  request valid
- req_i  in  128  request packet; bits, MSB first: padding[127:112], addr[111:80], op[79:72], op_ex[71:64], payload[63:32], src_y_cord[31:24], src_x_cord[23:16], y_cord[15:8], x_cord[7:0]
- req_ready_o  out  1  request ready
- rsp_v_o  out  1  response valid
- rsp_o  out  128  response packet; bits, MSB first: padding[127:88], pkt_type[87:80], data[79:48], load_id[47:16], y_cord[15:8], x_cord[7:0]
- rsp_ready_i  in  1  response ready
- load_cnt_o  out  cnt_width_p  completed loads, saturating
- store_cnt_o  out  cnt_width_p  completed stores, saturating
- err_cnt_o  out  cnt_width_p  error responses sent, saturating

Behaviour:
- Handshakes are valid/ready; a transfer occurs on a rising edge when both are high. rsp_o is stable while rsp_v_o=1 and not yet accepted.
- FSM has two states.
  - IDLE: req_ready_o=1, rsp_v_o=0. On a request handshake, capture the decode, perform any memory access at that edge, then go to RESP.
  - RESP: req_ready_o=0, rsp_v_o=1. On a response handshake go to IDLE.
  - Peak throughput is 1 request per 2 cycles; request-accept to rsp_v_o latency is 1 cycle.
- Memory word index is addr[lg(mem_els_p)-1:0]; addr is a word address.
- The request is in range iff addr < mem_els_p.
- The request is local iff x_cord==my_x_i and y_cord==my_y_i.
- Decode, in priority order:
  - Not local, or out of range, or op not in {0,1,2}: error. No memory access. pkt_type=8'h02, data=0, load_id=payload.
  - op=0, load: synchronous read issued at the accept edge. pkt_type=8'h01, data=mem[index], load_id=payload.
  - op=1, store: mem[index]=payload at the accept edge; op_ex ignored. pkt_type=8'h00, data=0, load_id=0.
  - op=2, masked store: byte b of mem[index] is written with payload byte b iff op_ex[b]=1, for b in 0..3; op_ex[7:4] ignored. Response is the same as op=1. A mask of 0 is legal: no bytes change and a normal ack is still returned.
- Every response has y_cord=src_y_cord, x_cord=src_x_cord and padding=0.
- The read-after-write hazard cannot occur, since the FSM never overlaps accesses. A load that follows a store returns the stored value.
- Counters:
  - The counter matching the response's pkt_type increments by 1 on each response handshake.
  - Each counter saturates at all-ones and never wraps.
- Backpressure: while rsp_ready_i=0 the block holds in RESP indefinitely and keeps req_ready_o=0. The load data is held in a register and must not be re-read.
- Reset, asserted asynchronously at any time:
  - FSM goes to IDLE, rsp_v_o=0, req_ready_o=1, all counters 0, rsp_o=0.
  - Any pending response is discarded.
  - Memory contents are not reset; they are undefined at power-up and retained across reset.
- req_i is sampled only on a request handshake; its value at other times has no effect.

Test Plan:
- With my=(1,2), store op=1 addr=5 payload=32'hCAFE_0001 src=(3,4), then load addr=5 load_id=32'h77 -> responses are {type 00, data 0, id 0, y=3, x=4}, then {type 01, data 32'hCAFE_0001, id 32'h77, y=3, x=4}; store_cnt=1, load_cnt=1.
- Store 32'h11223344 to addr 9, masked store op_ex=4'b0101 payload=32'hAABBCCDD, then load addr 9 -> data 32'h11BB33DD.
- Request with x_cord=7 (not local), or addr=mem_els_p, or op=5 -> type 02 with load_id echoed; memory unchanged, verified by a follow-up load; err_cnt increments once per case.
- Hold rsp_ready_i=0 for 10 cycles after a load -> rsp_v_o=1 and rsp_o stable throughout, req_ready_o=0; a store to the same addr presented meanwhile is not accepted, and the released response carries the old data.
- Assert reset_i while in RESP -> same cycle rsp_v_o=0 and counters 0; after release req_ready_o=1, and a load returns data written before reset.
- Drive 2^16+3 stores with cnt_width_p=16 -> store_cnt_o holds 16'hFFFF.
